// File: rtl/liu_spi_sched.sv
// LIU SPI scheduler: round-robin between CPU single accesses and a periodic status poller, with a watchdog.
// Optional status-change interrupt is built when LIU_SPI_SCHED_IRQ_EN is defined.
module liu_spi_sched #(
  parameter int         N_CS        = 2,
  parameter int         POLL_DIV    = 1000,
  parameter logic [7:0] STATUS_ADDR = 8'h00,
  parameter int         TIMEOUT     = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              poll_en,
  input  logic              cpu_req,
  input  logic [1:0]        cpu_cs,
  input  logic              cpu_wr,
  input  logic [7:0]        cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [7:0]        cpu_rdata,
  output logic              eng_valid,
  input  logic              eng_ready,
  output logic [1:0]        eng_cs,
  output logic              eng_wr,
  output logic [7:0]        eng_addr,
  output logic [7:0]        eng_wdata,
  input  logic              eng_done,
  input  logic [7:0]        eng_rdata,
  output logic              eng_abort,
  output logic [8*N_CS-1:0] status_data,
  output logic [N_CS-1:0]   status_valid,
  output logic              poll_ovr,
  input  logic              poll_ovr_clr,
  output logic              irq,
  input  logic              irq_clr
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [15:0] DIV_LAST = 16'(POLL_DIV - 1);
  localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 1);
  localparam logic [1:0]  IDX_LAST = 2'(N_CS - 1);

  state_t      state, state_nxt;
  logic        cpu_pend;
  logic [1:0]  req_cs;
  logic        req_wr;
  logic [7:0]  req_addr;
  logic [7:0]  req_wdata;
  logic        gnt_cpu;
  logic        poll_pend;
  logic [15:0] tick_cnt;
  logic [15:0] wd_cnt;
  logic [1:0]  poll_idx;
  logic        grant, grant_cpu, done_ok, done_to;
  logic        fin, cpu_fin, poll_fin, poll_clr, period, pend_keep;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_cpu = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    case (state)
      IDLE: if (cpu_pend || poll_pend) begin
        grant     = 1'b1;
        // gnt_cpu holds the previous grant, so a tie goes to the other side
        grant_cpu = cpu_pend && (!poll_pend || !gnt_cpu);
        state_nxt = ISSUE;
      end
      ISSUE: if (eng_ready) state_nxt = WAIT;
      WAIT: begin
        if (eng_done) begin
          done_ok   = 1'b1;
          state_nxt = IDLE;
        end else if (wd_cnt == WD_LAST) begin
          done_to   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign fin       = done_ok | done_to;
  assign cpu_fin   = fin & gnt_cpu;
  assign poll_fin  = fin & ~gnt_cpu;
  assign poll_clr  = poll_fin && (poll_idx == IDX_LAST);
  assign period    = poll_en && tick && (tick_cnt == DIV_LAST);
  assign pend_keep = poll_pend && !poll_clr;

  assign eng_valid = (state == ISSUE);
  assign eng_abort = done_to;
  assign eng_cs    = !eng_valid ? 2'd0 : (gnt_cpu ? req_cs    : poll_idx);
  assign eng_wr    = eng_valid && gnt_cpu && req_wr;
  assign eng_addr  = !eng_valid ? 8'd0 : (gnt_cpu ? req_addr  : STATUS_ADDR);
  assign eng_wdata = !eng_valid ? 8'd0 : (gnt_cpu ? req_wdata : 8'd0);
  assign cpu_busy  = cpu_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt_cpu <= 1'b0;
      wd_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (grant) gnt_cpu <= grant_cpu;
      if (state == ISSUE && eng_ready) wd_cnt <= '0;
      else if (state == WAIT)          wd_cnt <= wd_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_pend  <= 1'b0;
      req_cs    <= '0;
      req_wr    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      if (cpu_req && !cpu_pend) begin
        cpu_pend  <= 1'b1;
        req_cs    <= cpu_cs;
        req_wr    <= cpu_wr;
        req_addr  <= cpu_addr;
        req_wdata <= cpu_wdata;
      end else if (cpu_fin) begin
        cpu_pend <= 1'b0;
      end
      cpu_ack <= cpu_fin;
      cpu_err <= cpu_fin & done_to;
      if (cpu_fin && done_ok && !req_wr) cpu_rdata <= eng_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt  <= '0;
      poll_pend <= 1'b0;
      poll_ovr  <= 1'b0;
    end else begin
      if (!poll_en) begin
        tick_cnt  <= '0;
        poll_pend <= 1'b0;
      end else begin
        if (tick) tick_cnt <= (tick_cnt == DIV_LAST) ? 16'd0 : tick_cnt + 16'd1;
        if (period && !pend_keep) poll_pend <= 1'b1;
        else if (poll_clr)        poll_pend <= 1'b0;
      end
      if (period && pend_keep) poll_ovr <= 1'b1;
      else if (poll_ovr_clr)   poll_ovr <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_idx     <= '0;
      status_data  <= '0;
      status_valid <= '0;
    end else if (poll_fin) begin
      for (int k = 0; k < N_CS; k++) begin
        if (poll_idx == 2'(k)) begin
          if (done_ok) status_data[8*k +: 8] <= eng_rdata;
          status_valid[k] <= done_ok;
        end
      end
      poll_idx <= (poll_idx == IDX_LAST) ? 2'd0 : poll_idx + 2'd1;
    end
  end

`ifdef LIU_SPI_SCHED_IRQ_EN
  logic chg;

  always_comb begin
    chg = 1'b0;
    for (int k = 0; k < N_CS; k++) begin
      if (poll_idx == 2'(k) && status_valid[k] && status_data[8*k +: 8] != eng_rdata) chg = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            irq <= 1'b0;
    else if (poll_fin && done_ok && chg) irq <= 1'b1;
    else if (irq_clr)                   irq <= 1'b0;
  end
`else
  logic unused_irq_clr;
  assign unused_irq_clr = irq_clr;
  assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_liu_spi_sched.sv
// Directed bench for liu_spi_sched: CPU vector table plus poll, arbitration, watchdog, overrun, reset and irq sequences.
module tb_liu_spi_sched;

  logic        clk = 1'b0;
  logic        rst, tick, poll_en, cpu_req, cpu_wr, eng_ready, eng_done, poll_ovr_clr, irq_clr;
  logic [1:0]  cpu_cs, eng_cs;
  logic [7:0]  cpu_addr, cpu_wdata, cpu_rdata, eng_addr, eng_wdata, eng_rdata;
  logic        cpu_busy, cpu_ack, cpu_err, eng_valid, eng_wr, eng_abort, poll_ovr, irq;
  logic [15:0] status_data;
  logic [1:0]  status_valid;

  int errors = 0;
  int checks = 0;

`ifdef LIU_SPI_SCHED_IRQ_EN
  localparam int IRQ_EXP = 1;
`else
  localparam int IRQ_EXP = 0;
`endif

  always #5 clk = ~clk;

  liu_spi_sched #(.N_CS(2), .POLL_DIV(3), .STATUS_ADDR(8'h00), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .tick(tick), .poll_en(poll_en),
    .cpu_req(cpu_req), .cpu_cs(cpu_cs), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_cs(eng_cs), .eng_wr(eng_wr),
    .eng_addr(eng_addr), .eng_wdata(eng_wdata), .eng_done(eng_done), .eng_rdata(eng_rdata),
    .eng_abort(eng_abort), .status_data(status_data), .status_valid(status_valid),
    .poll_ovr(poll_ovr), .poll_ovr_clr(poll_ovr_clr), .irq(irq), .irq_clr(irq_clr)
  );

  typedef struct {
    logic [1:0] cs;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] reply;
    logic [7:0] exp_rdata;
  } cpu_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gpack(input logic [1:0] cs, input logic wr, input logic [7:0] addr);
    return {21'd0, cs, wr, addr};
  endfunction

  task automatic wait_valid();
    int n = 0;
    while (!eng_valid && n < 40) begin
      step();
      n++;
    end
    check("eng_valid_wait", 32'(eng_valid), 1);
  endtask

  // Engine model: accept the request, reply with rd after lat WAIT cycles
  task automatic engine(input logic [7:0] rd, input int lat, output logic [31:0] g);
    wait_valid();
    g = gpack(eng_cs, eng_wr, eng_addr);
    eng_ready = 1'b1;
    step();
    eng_ready = 1'b0;
    repeat (lat - 1) step();
    eng_done  = 1'b1;
    eng_rdata = rd;
    step();
    eng_done  = 1'b0;
  endtask

  task automatic cpu_issue(input logic [1:0] cs, input logic wr, input logic [7:0] addr, input logic [7:0] wd);
    cpu_cs = cs; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    step();
    cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    cpu_vec_t    vecs [4];
    logic [31:0] g;
    int          abort_at;

    vecs[0] = '{cs: 2'd1, wr: 1'b1, addr: 8'h12, wdata: 8'h7E, reply: 8'h55, exp_rdata: 8'h00};
    vecs[1] = '{cs: 2'd0, wr: 1'b0, addr: 8'h34, wdata: 8'h00, reply: 8'hC3, exp_rdata: 8'hC3};
    vecs[2] = '{cs: 2'd2, wr: 1'b1, addr: 8'h56, wdata: 8'h9A, reply: 8'h11, exp_rdata: 8'hC3};
    vecs[3] = '{cs: 2'd3, wr: 1'b0, addr: 8'hFF, wdata: 8'h00, reply: 8'h00, exp_rdata: 8'h00};

    rst = 1'b1; tick = 1'b0; poll_en = 1'b0; cpu_req = 1'b0; cpu_cs = 2'd0; cpu_wr = 1'b0;
    cpu_addr = 8'd0; cpu_wdata = 8'd0; eng_ready = 1'b0; eng_done = 1'b0; eng_rdata = 8'd0;
    poll_ovr_clr = 1'b0; irq_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {24'd0, cpu_busy, cpu_ack, cpu_err, eng_valid, eng_wr, eng_abort, poll_ovr, irq}, 0);
    check("rst_status", {14'd0, status_valid, status_data}, 0);
    check("rst_rdata", 32'(cpu_rdata), 0);
    rst = 1'b0;
    step();

    // CPU vectors; a second request during the accept cycle must be ignored
    for (int i = 0; i < 4; i++) begin
      cpu_issue(vecs[i].cs, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      check("lat_busy_t1", 32'(cpu_busy), 1);
      check("lat_valid_t1", 32'(eng_valid), 0);
      step();
      check("lat_valid_t2", 32'(eng_valid), 1);
      check("cpu_fields", {eng_wdata, 13'd0, eng_cs, eng_wr, eng_addr},
            {vecs[i].wdata, 13'd0, vecs[i].cs, vecs[i].wr, vecs[i].addr});
      eng_ready = 1'b1; cpu_req = 1'b1; cpu_cs = 2'd3; cpu_addr = 8'hEE;
      step();
      eng_ready = 1'b0; cpu_req = 1'b0;
      step();
      eng_done = 1'b1; eng_rdata = vecs[i].reply;
      step();
      eng_done = 1'b0;
      check("cpu_ack", {29'd0, cpu_ack, cpu_busy, cpu_err}, 32'b100);
      check("cpu_rdata", 32'(cpu_rdata), 32'(vecs[i].exp_rdata));
      step();
      check("ack_pulse_idle", {30'd0, cpu_ack, eng_valid | cpu_busy}, 0);
    end

    // Poll round with 3 ticks, 2-cycle engine latency
    poll_en = 1'b1;
    tick = 1'b1;
    repeat (3) step();
    tick = 1'b0;
    engine(8'hA5, 2, g);
    check("poll_cs0_grant", g, gpack(2'd0, 1'b0, 8'h00));
    engine(8'h3C, 2, g);
    check("poll_cs1_grant", g, gpack(2'd1, 1'b0, 8'h00));
    check("poll_status", {14'd0, status_valid, status_data}, {14'd0, 2'b11, 16'h3CA5});

    // Arbitration: CPU and poll pending together, then CPU again during the poll
    tick = 1'b1;
    repeat (2) step();
    cpu_cs = 2'd2; cpu_wr = 1'b0; cpu_addr = 8'h31; cpu_wdata = 8'h00; cpu_req = 1'b1;
    step();
    tick = 1'b0; cpu_req = 1'b0;
    engine(8'h77, 2, g);
    check("arb_1_cpu", g, gpack(2'd2, 1'b0, 8'h31));
    cpu_issue(2'd3, 1'b1, 8'h44, 8'h99);
    engine(8'h5A, 2, g);
    check("arb_2_poll0", g, gpack(2'd0, 1'b0, 8'h00));
    engine(8'hEE, 2, g);
    check("arb_3_cpu", g, gpack(2'd3, 1'b1, 8'h44));
    engine(8'hC3, 2, g);
    check("arb_4_poll1", g, gpack(2'd1, 1'b0, 8'h00));
    check("arb_status", 32'(status_data), 'hC35A);
    check("arb_rdata", 32'(cpu_rdata), 'h77);
    poll_en = 1'b0;
    step();

    // Watchdog: engine never answers a CPU read
    cpu_issue(2'd1, 1'b0, 8'h40, 8'h00);
    wait_valid();
    eng_ready = 1'b1;
    step();
    eng_ready = 1'b0;
    abort_at = -1;
    for (int i = 0; i < 20; i++) begin
      if (eng_abort) begin
        abort_at = i;
        break;
      end
      step();
    end
    check("abort_cycle", 32'(abort_at), 15);
    step();
    check("to_ack_err", {30'd0, cpu_ack, cpu_err}, 32'b11);
    check("to_rdata_held", 32'(cpu_rdata), 'h77);
    step();
    check("abort_pulse", {30'd0, eng_abort, cpu_ack}, 0);

    // eng_done coincident with watchdog expiry counts as done
    cpu_issue(2'd0, 1'b0, 8'h41, 8'h00);
    wait_valid();
    eng_ready = 1'b1;
    step();
    eng_ready = 1'b0;
    repeat (15) step();
    eng_done = 1'b1; eng_rdata = 8'h6B;
    #1;
    check("tie_no_abort", 32'(eng_abort), 0);
    step();
    check("tie_ack_ok", {30'd0, cpu_ack, cpu_err}, 32'b10);
    check("tie_rdata", 32'(cpu_rdata), 'h6B);
    eng_rdata = 8'hFF;
    step();
    eng_done = 1'b0;
    step();
    check("done_in_idle", {23'd0, cpu_ack, cpu_rdata}, 'h6B);

    // Overrun while the engine stalls eng_ready
    poll_en = 1'b1;
    tick = 1'b1;
    repeat (6) step();
    tick = 1'b0;
    check("ovr_stall_valid", 32'(eng_valid), 1);
    check("ovr_set", 32'(poll_ovr), 1);
    poll_ovr_clr = 1'b1;
    step();
    poll_ovr_clr = 1'b0;
    check("ovr_clr", 32'(poll_ovr), 0);
    tick = 1'b1;
    repeat (2) step();
    poll_ovr_clr = 1'b1;
    step();
    tick = 1'b0; poll_ovr_clr = 1'b0;
    check("ovr_wins_clr", 32'(poll_ovr), 1);
    eng_ready = 1'b1;
    step();
    eng_ready = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("rst_mid_wait", {15'd0, eng_valid, cpu_busy, poll_ovr, cpu_ack, status_valid, 11'd0}, 0);
    check("rst_mid_status", {16'd0, status_data}, 0);
    step();
    rst = 1'b0;
    poll_en = 1'b0;
    step();

    // Status-change interrupt: CS0 reads 01, 01, 03
    poll_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      tick = 1'b1;
      repeat (3) step();
      tick = 1'b0;
      engine((r == 2) ? 8'h03 : 8'h01, 2, g);
      check("irq_after_cs0", 32'(irq), (r == 2) ? IRQ_EXP : 0);
      engine(8'h00, 2, g);
    end
    check("irq_hold", 32'(irq), IRQ_EXP);
    check("irq_status", {14'd0, status_valid, status_data}, {14'd0, 2'b11, 16'h0003});
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    check("irq_clr", 32'(irq), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
